// File: rtl/dense_controller.sv
// -----------------------------------------------------------------------------
// dense_controller
//   Sequencing FSM for the dense-layer datapath. Consumes one full input
//   vector from the input buffer, runs IN_COUNT multiply-accumulate cycles per
//   output neuron, adds the bias and writes the result word, and finally
//   hands a complete output vector to the downstream buffer.
//
//   Memories with a fixed read latency MEM_LAT (0..3) are supported: load is
//   inCntEn delayed by MEM_LAT cycles, and a DRAIN phase of MEM_LAT cycles
//   lets the last in-flight product land before the bias cycle.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     input buffer holds a complete vector
//   in_consume   1-cycle pulse: input vector fully used
//   out_valid    output buffer holds a complete result vector
//   out_ready    downstream took the result (handshake in WAIT_OUT)
//   clear        clear both datapath index counters
//   inCntEn      advance input index counter
//   clearReg     clear partial-sum register
//   WorB         adder mux select: 0 = product, 1 = bias
//   load         load partial-sum register
//   outCntEn     advance output index counter
//   outWrEn      write result word (partial sum + bias)
//   mulDone      input counter at terminal count
//   calcDone     output counter at terminal count
//   busy         FSM not idle
//   err          sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------
module dense_controller #(
    parameter int IN_COUNT  = 784,
    parameter int OUT_COUNT = 10,
    parameter int MEM_LAT   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_consume,
    output logic out_valid,
    input  logic out_ready,
    output logic clear,
    output logic inCntEn,
    output logic clearReg,
    output logic WorB,
    output logic load,
    output logic outCntEn,
    output logic outWrEn,
    input  logic mulDone,
    input  logic calcDone,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        MAC      = 3'd2,
        DRAIN    = 3'd3,
        BIAS     = 3'd4,
        WAIT_OUT = 3'd5
    } stateT;

    localparam int WD_W = $clog2(IN_COUNT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(IN_COUNT - 1);
    localparam logic [1:0] DRAIN_LAST = 2'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam int OI_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

    stateT           state, nextState;
    logic [1:0]      drainCnt;
    logic [WD_W-1:0] wdCnt;
    logic [OI_W-1:0] outIdx;
    logic            wdFire;
    logic            macDone;

    // Watchdog: the IN_COUNT-th MAC cycle without mulDone ends the MAC phase
    // anyway so a broken counter cannot hang the layer.
    assign wdFire  = (state == MAC) && !mulDone && (wdCnt == WD_LAST);
    assign macDone = mulDone || wdFire;
    assign busy    = (state != IDLE);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------- next state and outputs
    always_comb begin
        nextState  = state;
        clear      = 1'b0;
        inCntEn    = 1'b0;
        clearReg   = 1'b0;
        WorB       = 1'b0;
        outCntEn   = 1'b0;
        outWrEn    = 1'b0;
        out_valid  = 1'b0;
        in_consume = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) nextState = INIT;
            end
            INIT: begin
                clear     = 1'b1;
                clearReg  = 1'b1;
                nextState = MAC;
            end
            MAC: begin
                inCntEn = 1'b1;
                // A forced exit also drains, so the load pipe is empty
                // when clearReg fires in BIAS.
                if (macDone) nextState = (MEM_LAT > 0) ? DRAIN : BIAS;
            end
            DRAIN: begin
                if (drainCnt == DRAIN_LAST) nextState = BIAS;
            end
            BIAS: begin
                WorB     = 1'b1;
                outWrEn  = 1'b1;
                outCntEn = 1'b1;
                clearReg = 1'b1;
                if (calcDone) begin
                    in_consume = 1'b1;
                    nextState  = WAIT_OUT;
                end else begin
                    nextState  = MAC;
                end
            end
            WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // --------------------------------------------- drain / watchdog counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drainCnt <= '0;
            wdCnt    <= '0;
            err      <= 1'b0;
        end else begin
            drainCnt <= (state == DRAIN) ? drainCnt + 2'd1 : 2'd0;
            wdCnt    <= (state == MAC) ? wdCnt + 1'b1 : '0;
            if (wdFire) err <= 1'b1;
        end
    end

    // Output-word index, tracked only to cross-check calcDone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outIdx <= '0;
        end else if (state == INIT) begin
            outIdx <= '0;
        end else if (state == BIAS) begin
            outIdx <= outIdx + 1'b1;
        end
    end

    // ------------------------------------------------------------ load pipe
    // load mirrors inCntEn shifted by the memory read latency so the
    // accumulator adds each product on the cycle its operands arrive.
    generate
        if (MEM_LAT == 0) begin : gNoLat
            assign load = inCntEn;
        end else begin : gLat
            logic [MEM_LAT-1:0] loadPipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    loadPipe <= '0;
                end else begin
                    loadPipe[0] <= inCntEn;
                    for (int i = 1; i < MEM_LAT; i++) begin
                        loadPipe[i] <= loadPipe[i-1];
                    end
                end
            end
            assign load = loadPipe[MEM_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------ assertions
    aClearLoad : assert property (@(posedge clk) disable iff (rst)
        !(clearReg && load));
    aLastWord : assert property (@(posedge clk) disable iff (rst)
        in_consume |-> (outIdx == OI_W'(OUT_COUNT - 1)));

endmodule

// File: tb/tb_dense_controller.sv
module tb_dense_controller;

    localparam int IN_N  = 4;
    localparam int OUT_N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inValid = 1'b0;
    logic outReady = 1'b0;
    logic noMul = 1'b0;

    int checkCnt = 0;
    int passCnt  = 0;
    int overlapCnt = 0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT A (LAT=0)
    logic inConsumeA, outValidA, clearA, inCntEnA, clearRegA, WorBA, loadA;
    logic outCntEnA, outWrEnA, mulDoneA, calcDoneA, busyA, errA;
    logic [10:0] vecA;

    dense_controller #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .MEM_LAT(0)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_consume(inConsumeA),
        .out_valid(outValidA), .out_ready(outReady), .clear(clearA),
        .inCntEn(inCntEnA), .clearReg(clearRegA), .WorB(WorBA), .load(loadA),
        .outCntEn(outCntEnA), .outWrEn(outWrEnA), .mulDone(mulDoneA),
        .calcDone(calcDoneA), .busy(busyA), .err(errA)
    );

    // ------------------------------------------------------------ DUT B (LAT=2)
    logic inConsumeB, outValidB, clearB, inCntEnB, clearRegB, WorBB, loadB;
    logic outCntEnB, outWrEnB, mulDoneB, calcDoneB, busyB, errB;
    logic [10:0] vecB;

    dense_controller #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .MEM_LAT(2)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_consume(inConsumeB),
        .out_valid(outValidB), .out_ready(outReady), .clear(clearB),
        .inCntEn(inCntEnB), .clearReg(clearRegB), .WorB(WorBB), .load(loadB),
        .outCntEn(outCntEnB), .outWrEn(outWrEnB), .mulDone(mulDoneB),
        .calcDone(calcDoneB), .busy(busyB), .err(errB)
    );

    assign vecA = {clearA, clearRegA, inCntEnA, loadA, WorBA, outCntEnA,
                   outWrEnA, inConsumeA, outValidA, busyA, errA};
    assign vecB = {clearB, clearRegB, inCntEnB, loadB, WorBB, outCntEnB,
                   outWrEnB, inConsumeB, outValidB, busyB, errB};

    // ------------------------------------------------------- datapath models
    int xv[4]    = '{1, 2, 3, 4};
    int wv[3][4] = '{'{1, 1, 1, 1}, '{2, 0, -1, 1}, '{3, 2, 1, 0}};
    int bv[3]    = '{5, -1, 7};
    int expOut[3] = '{15, 2, 17};

    int inIdxA, outIdxA, psumA;
    int bufA[3];
    int inIdxB, outIdxB, psumB, prodB, prodB1, prodB2;
    int bufB[3];

    assign mulDoneA  = !noMul && (inIdxA == IN_N - 1);
    assign calcDoneA = (outIdxA == OUT_N - 1);
    assign mulDoneB  = (inIdxB == IN_N - 1);
    assign calcDoneB = (outIdxB == OUT_N - 1);

    always_comb prodB = xv[inIdxB] * wv[outIdxB][inIdxB];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inIdxA <= 0; outIdxA <= 0; psumA <= 0;
            for (int i = 0; i < 3; i++) bufA[i] <= 0;
        end else begin
            if (clearA) begin
                inIdxA <= 0; outIdxA <= 0;
            end else begin
                if (inCntEnA) inIdxA <= (inIdxA == IN_N - 1) ? 0 : inIdxA + 1;
                if (outCntEnA) outIdxA <= (outIdxA == OUT_N - 1) ? 0 : outIdxA + 1;
            end
            if (clearRegA) psumA <= 0;
            else if (loadA) psumA <= psumA + xv[inIdxA] * wv[outIdxA][inIdxA];
            if (outWrEnA && WorBA) bufA[outIdxA] <= psumA + bv[outIdxA];
        end
    end

    // Two-cycle read latency: the product of the issued address arrives
    // two cycles later, aligned with load.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inIdxB <= 0; outIdxB <= 0; psumB <= 0; prodB1 <= 0; prodB2 <= 0;
            for (int i = 0; i < 3; i++) bufB[i] <= 0;
        end else begin
            if (clearB) begin
                inIdxB <= 0; outIdxB <= 0;
            end else begin
                if (inCntEnB) inIdxB <= (inIdxB == IN_N - 1) ? 0 : inIdxB + 1;
                if (outCntEnB) outIdxB <= (outIdxB == OUT_N - 1) ? 0 : outIdxB + 1;
            end
            prodB1 <= prodB;
            prodB2 <= prodB1;
            if (clearRegB) psumB <= 0;
            else if (loadB) psumB <= psumB + prodB2;
            if (outWrEnB && WorBB) bufB[outIdxB] <= psumB + bv[outIdxB];
        end
    end

    always @(negedge clk) begin
        if (!rst && ((clearRegA && loadA) || (clearRegB && loadB)))
            overlapCnt <= overlapCnt + 1;
    end

    // ------------------------------------------------------------ utilities
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Expected nominal timeline, cycle k after in_valid sampled at cycle 0.
    // Bit order matches vecA/vecB.
    function automatic logic [10:0] expVec(int k, int lat);
        int per, j, p, jl, pl;
        logic mac, ld, bias, last;
        per = IN_N + lat + 1;
        mac = 1'b0; ld = 1'b0; bias = 1'b0; last = 1'b0;
        if (k >= 2) begin
            j = (k - 2) / per; p = (k - 2) % per;
            if (j < OUT_N) begin
                mac  = (p < IN_N);
                bias = (p == per - 1);
                last = bias && (j == OUT_N - 1);
            end
        end
        if (k >= 2 + lat) begin
            jl = (k - 2 - lat) / per; pl = (k - 2 - lat) % per;
            if (jl < OUT_N) ld = (pl < IN_N);
        end
        return {(k == 1), (k == 1) || bias, mac, ld, bias, bias, bias, last,
                (k >= 2 + OUT_N * per), (k >= 1), 1'b0};
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checkCnt++;
        if (vecA !== 11'b0) $display("FAIL reset_outA got=%b exp=%b", vecA, 11'b0);
        else passCnt++;
        checkCnt++;
        if (vecB !== 11'b0) $display("FAIL reset_outB got=%b exp=%b", vecB, 11'b0);
        else passCnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        logic [10:0] e;
        doReset();
        inValid = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            inValid = 1'b0;
            e = expVec(k, 0);
            checkCnt++;
            if (vecA !== e) $display("FAIL nominal_lat0 cyc=%0d got=%b exp=%b", k, vecA, e);
            else passCnt++;
            e = expVec(k, 2);
            checkCnt++;
            if (vecB !== e) $display("FAIL nominal_lat2 cyc=%0d got=%b exp=%b", k, vecB, e);
            else passCnt++;
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkCnt++;
        if (vecA !== 11'b0) $display("FAIL handshake_idleA got=%b exp=%b", vecA, 11'b0);
        else passCnt++;
        checkCnt++;
        if (vecB !== 11'b0) $display("FAIL handshake_idleB got=%b exp=%b", vecB, 11'b0);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] got, e;
        doReset();
        inValid = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            outReady = (k == 27);
            got = {clearA, outValidA, inConsumeA};
            e   = {(k == 1) || (k == 29), (k >= 17) && (k <= 27), (k == 16)};
            checkCnt++;
            if (got !== e) $display("FAIL backpressure cyc=%0d got=%b exp=%b", k, got, e);
            else passCnt++;
        end
        inValid = 1'b0;
        outReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] got, e;
        doReset();
        inValid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            inValid = 1'b0;
        end
        checkCnt++;
        if (inCntEnA !== 1'b1) $display("FAIL midreset_in_mac got=%b exp=%b", inCntEnA, 1'b1);
        else passCnt++;
        rst = 1'b1;
        #1;
        checkCnt++;
        if (vecA !== 11'b0) $display("FAIL midreset_outA got=%b exp=%b", vecA, 11'b0);
        else passCnt++;
        checkCnt++;
        if (vecB !== 11'b0) $display("FAIL midreset_outB got=%b exp=%b", vecB, 11'b0);
        else passCnt++;
        tick(); tick();
        rst = 1'b0;
        tick();
        checkCnt++;
        if (vecA !== 11'b0) $display("FAIL midreset_after got=%b exp=%b", vecA, 11'b0);
        else passCnt++;
        inValid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            inValid = 1'b0;
            if (k == 1 || k >= 16) begin
                got = {clearA, outValidA};
                e   = {(k == 1), (k == 17)};
                checkCnt++;
                if (got !== e) $display("FAIL midreset_relaunch cyc=%0d got=%b exp=%b", k, got, e);
                else passCnt++;
            end
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [2:0] got, e;
        doReset();
        noMul = 1'b1;
        inValid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            inValid = 1'b0;
            got = {errA, outWrEnA, outValidA};
            e   = {(k >= 6), (k == 6) || (k == 11) || (k == 16), (k == 17)};
            checkCnt++;
            if (got !== e) $display("FAIL watchdog cyc=%0d got=%b exp=%b", k, got, e);
            else passCnt++;
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        tick(); tick();
        got = {errA, busyA, outValidA};
        checkCnt++;
        if (got !== 3'b100) $display("FAIL watchdog_sticky got=%b exp=%b", got, 3'b100);
        else passCnt++;
        noMul = 1'b0;
        doReset();
        checkCnt++;
        if (errA !== 1'b0) $display("FAIL watchdog_clear got=%b exp=%b", errA, 1'b0);
        else passCnt++;
    endtask

    task automatic test_datapath();
        doReset();
        overlapCnt = 0;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        for (int k = 2; k <= 24; k++) tick();
        for (int o = 0; o < OUT_N; o++) begin
            checkCnt++;
            if (bufA[o] !== expOut[o]) $display("FAIL datapath_lat0 word=%0d got=%0d exp=%0d", o, bufA[o], expOut[o]);
            else passCnt++;
            checkCnt++;
            if (bufB[o] !== expOut[o]) $display("FAIL datapath_lat2 word=%0d got=%0d exp=%0d", o, bufB[o], expOut[o]);
            else passCnt++;
        end
        checkCnt++;
        if (overlapCnt !== 0) $display("FAIL clearreg_load_overlap got=%0d exp=%0d", overlapCnt, 0);
        else passCnt++;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_reset_mid();
        test_watchdog();
        test_datapath();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    // Absolute bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
